// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: CPU-side channel ports plus the physical memory port of the arbiter.
interface mem_port_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  localparam int MASK_W = DATA_W / 8;
  logic [NUM_CH-1:0]        ch_read;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH*MASK_W-1:0] ch_byte_enable;
  logic [NUM_CH-1:0]        ch_resp;
  logic [DATA_W-1:0]        ch_rdata;
  logic                     mem_read;
  logic                     mem_write;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [MASK_W-1:0]        mem_byte_enable;
  logic                     mem_resp;
  logic [DATA_W-1:0]        mem_rdata;
  modport slave (
    input  ch_read, ch_write, ch_addr, ch_wdata, ch_byte_enable, mem_resp, mem_rdata,
    output ch_resp, ch_rdata, mem_read, mem_write, mem_addr, mem_wdata, mem_byte_enable
  );
  modport master (
    output ch_read, ch_write, ch_addr, ch_wdata, ch_byte_enable, mem_resp, mem_rdata,
    input  ch_resp, ch_rdata, mem_read, mem_write, mem_addr, mem_wdata, mem_byte_enable
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges NUM_CH LC-3b memory ports onto one physical port (fixed priority or round-robin).
module mem_port_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int RR_MODE = 0
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave io_bus
);
  localparam int MASK_W = DATA_W / 8;
  localparam int IW = $clog2(NUM_CH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            r_state;
  logic [IW-1:0]     r_ptr, r_grant, w_base, w_off, w_win, w_next;
  logic [IW:0]       w_sum;
  logic [NUM_CH-1:0] w_req, w_rot, r_ch_resp;
  logic              r_mem_read, r_mem_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [MASK_W-1:0] r_be;
  assign w_req  = io_bus.ch_read | io_bus.ch_write;
  assign w_base = RR_MODE != 0 ? r_ptr : '0;
  // Rotate requests so the search origin sits at bit 0, then map the hit back.
  assign w_rot  = NUM_CH'({w_req, w_req} >> w_base);
  always_comb begin
    w_off = '0;
    for (int j = NUM_CH - 1; j >= 0; j--) w_off = w_rot[IW'(j)] ? IW'(j) : w_off;
  end
  assign w_sum  = {1'b0, w_base} + {1'b0, w_off};
  assign w_win  = w_sum >= (IW+1)'(NUM_CH) ? IW'(w_sum - (IW+1)'(NUM_CH)) : w_sum[IW-1:0];
  assign w_next = w_win == IW'(NUM_CH - 1) ? '0 : w_win + IW'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_rdata     <= '0;
      r_ch_resp   <= '0;
    end else begin
      case (r_state)
        IDLE: if (|w_req) begin
          r_state     <= BUSY;
          r_grant     <= w_win;
          r_ptr       <= w_next;
          r_mem_read  <= io_bus.ch_read[w_win];
          r_mem_write <= !io_bus.ch_read[w_win];
          r_addr      <= ADDR_W'(io_bus.ch_addr >> (int'(w_win) * ADDR_W));
          r_wdata     <= DATA_W'(io_bus.ch_wdata >> (int'(w_win) * DATA_W));
          r_be        <= MASK_W'(io_bus.ch_byte_enable >> (int'(w_win) * MASK_W));
        end
        BUSY: if (io_bus.mem_resp) begin
          r_state     <= DONE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_ch_resp   <= NUM_CH'(1) << r_grant;
          r_rdata     <= r_mem_read ? io_bus.mem_rdata : r_rdata;
        end
        DONE: begin
          r_state   <= IDLE;
          r_ch_resp <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign io_bus.mem_read        = r_mem_read;
  assign io_bus.mem_write       = r_mem_write;
  assign io_bus.mem_addr        = r_addr;
  assign io_bus.mem_wdata       = r_wdata;
  assign io_bus.mem_byte_enable = r_be;
  assign io_bus.ch_resp         = r_ch_resp;
  assign io_bus.ch_rdata        = r_rdata;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised arbiter that merges NUM_CH independent CPU-side memory ports onto one physical memory port, and replaces the fixed split instruction/data memory interface at the mp3 top level. The default configuration has 2 channels: channel 0 is the instruction port and channel 1 is the data port. Both fixed-priority and round-robin modes are supported. Each channel keeps the existing LC-3b memory protocol: the request is held until a one-cycle resp pulse.

## Interface
- NUM_CH, 2 — number of requesting channels, range 2..8.
- ADDR_W, 16 — address width.
- DATA_W, 16 — data width; must be a multiple of 8.
- MASK_W, DATA_W/8 — byte-enable width; derived, not overridable.
- RR_MODE, 0 — 0 selects fixed priority (lowest index wins); 1 selects round-robin.

Ports:
- clk  in  1  — single clock; all state updates on the rising edge.
- rst  in  1  — asynchronous, active-high reset.
- ch_read  in  NUM_CH  — per-channel read request.
- ch_write  in  NUM_CH  — per-channel write request.
- ch_addr  in  NUM_CH*ADDR_W  — per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*DATA_W  — per-channel write data, packed the same way.
- ch_byte_enable  in  NUM_CH*MASK_W  — per-channel byte mask, packed the same way.
- ch_resp  out  NUM_CH  — one-cycle completion pulse to the granted channel.
- ch_rdata  out  DATA_W  — read data, broadcast to all channels.
- mem_read  out  1  — physical memory read strobe.
- mem_write  out  1  — physical memory write strobe.
- mem_addr  out  ADDR_W  — physical memory address.
- mem_wdata  out  DATA_W  — physical memory write data.
- mem_byte_enable  out  MASK_W  — physical memory byte mask.
- mem_resp  in  1  — physical memory completion.
- mem_rdata  in  DATA_W  — physical memory read data.

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- **IDLE:**
  - A channel is requesting when its ch_read or ch_write is high.
  - If any channel is requesting, select a winner, latch its grant index, rw flag, addr, wdata and byte_enable into registers, and go to BUSY.
  - If no channel is requesting, stay in IDLE.
- **Arbitration:**
  - RR_MODE=0: the lowest-index requesting channel wins.
  - RR_MODE=1: the search starts at pointer ptr and wraps upward modulo NUM_CH.
  - On each grant to channel g, ptr is set to (g+1) mod NUM_CH; a grant to NUM_CH-1 sets ptr to 0.
- **Read/write conflict:** if a channel asserts ch_read and ch_write together, the operation issues as a read and the write is dropped.
- **BUSY:**
  - mem_read or mem_write is driven high from the latched rw flag for every BUSY cycle.
  - mem_addr, mem_wdata and mem_byte_enable come from the latched registers and stay stable for the whole transaction.
  - On mem_resp=1, capture mem_rdata into ch_rdata (reads only) and go to DONE.
- **DONE:**
  - ch_resp[grant] is high for exactly this cycle; all other ch_resp bits are 0.
  - mem_read and mem_write are 0.
  - The FSM always returns to IDLE; no grant is made in DONE. This guarantees the completed channel's still-asserted request is never re-granted.
- **Channel input changes during BUSY:** ignored, because the command was latched at grant time.
- **Reset:** rst forces state IDLE and ptr=0 asynchronously, so an in-flight transaction is abandoned. A mem_resp arriving while in IDLE or DONE is ignored.

## Timing
- **Reset values:**
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, mem_byte_enable=0.
  - ch_resp all 0, ch_rdata=0.
  - Internal state IDLE, ptr=0.
- **Latency:**
  - A request first seen in IDLE at cycle t gives mem_read/mem_write high at t+1.
  - mem_resp at cycle m gives ch_resp at m+1.
  - The minimum request-to-resp time is 3 cycles, when memory responds in the first BUSY cycle.
- **Throughput:** back-to-back transactions take at least 3 cycles each (IDLE, BUSY, DONE).
- **ch_rdata:** updates on the edge entering DONE and holds its value until the next read completes; writes do not modify it.
- **Outputs:** all outputs are registered or decoded from state only, with no combinational path from ch_* inputs.
- **Requester obligation:** hold ch_read/ch_write and the command fields until ch_resp is seen, and deassert or change them on the following edge.

## Test plan
- **Single read:** reset, then ch_read[1]=1 with addr 0x1234, memory answering 0xBEEF after 2 BUSY cycles → mem_read high for 2 cycles with mem_addr=0x1234; ch_resp[1] pulses for one cycle with ch_rdata=0xBEEF; ch_resp[0] stays 0.
- **Fixed-priority contention** (RR_MODE=0, NUM_CH=2, both channels reading continuously) → channel 0 is granted every transaction and channel 1 is starved, with no double grant.
- **Round-robin** (RR_MODE=1, NUM_CH=4, all channels requesting) → grant order 0,1,2,3,0; ptr wraps from 3 to 0.
- **Write with byte mask:** ch_write[0]=1, wdata=0xA5C3, byte_enable=2'b01 → mem_write=1, mem_wdata=0xA5C3, mem_byte_enable=2'b01; ch_rdata unchanged from its previous value.
- **Read/write conflict and input change:** ch_read and ch_write both high on one channel → mem_read issues, mem_write stays 0. Changing ch_addr during BUSY leaves mem_addr unchanged.
- **Reset mid-transaction:** assert rst during BUSY → mem_read drops immediately and ch_resp stays 0. A mem_resp after reset release is ignored, and the next grant starts from ptr=0.
